// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the ID/EX pipeline stages and the hazard controller.
// master: pipeline side (drives decode/EX info, receives enables).
// slave : hazard controller (receives decode/EX info, drives enables).
interface pipeline_hazard_ctrl_if;
  logic [4:0]  ID_Rs;
  logic [4:0]  ID_Rt;
  logic        ID_uses_rs;
  logic        ID_uses_rt;
  logic        ID_is_muldiv;
  logic        ID_muldiv_op;
  logic        ID_reads_hilo;
  logic        EX_memread;
  logic        EX_regwrite;
  logic [4:0]  EX_writereg;
  logic        EX_branch_taken;
  logic        PC_write;
  logic        IFID_write;
  logic        IFID_flush;
  logic        IDEX_flush;
  logic        muldiv_start;
  logic        muldiv_busy;
  logic        muldiv_done;
  logic [31:0] stall_cycles;

  modport master (
    output ID_Rs, ID_Rt, ID_uses_rs, ID_uses_rt, ID_is_muldiv, ID_muldiv_op,
           ID_reads_hilo, EX_memread, EX_regwrite, EX_writereg, EX_branch_taken,
    input  PC_write, IFID_write, IFID_flush, IDEX_flush, muldiv_start,
           muldiv_busy, muldiv_done, stall_cycles
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_uses_rs, ID_uses_rt, ID_is_muldiv, ID_muldiv_op,
           ID_reads_hilo, EX_memread, EX_regwrite, EX_writereg, EX_branch_taken,
    output PC_write, IFID_write, IFID_flush, IDEX_flush, muldiv_start,
           muldiv_busy, muldiv_done, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use detection,
// taken-branch flushing, MULT/DIV issue and occupancy tracking, and a
// saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  // Counter reload values: the counter reaches zero in the final BUSY cycle.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_done;
  logic [31:0]      r_stall_cycles;

  logic w_load_use;
  logic w_struct;
  logic w_busy;
  logic w_start;
  logic w_stall_inc;
  logic w_pc_write;
  logic w_ifid_write;
  logic w_ifid_flush;
  logic w_idex_flush;

  assign w_busy = (r_state == S_BUSY);

  // Hazard terms; register $0 never creates a dependency.
  assign w_load_use = bus.EX_memread && bus.EX_regwrite && (bus.EX_writereg != 5'd0) &&
                      ((bus.ID_uses_rs && (bus.ID_Rs == bus.EX_writereg)) ||
                       (bus.ID_uses_rt && (bus.ID_Rt == bus.EX_writereg)));
  assign w_struct   = w_busy && (bus.ID_is_muldiv || bus.ID_reads_hilo);

  // State, occupancy counter and done pulse; done marks the BUSY->IDLE edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_done  <= w_busy && (r_cnt == '0);
    end
  end

  // Next state: issue from IDLE, count down while BUSY.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_next = S_BUSY;
          w_cnt_next   = bus.ID_muldiv_op ? DIV_LOAD : MUL_LOAD;
        end
      end
      S_BUSY: begin
        if (r_cnt == '0) begin
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Pipeline enables: a taken branch wins over any stall, stalls over normal flow.
  always_comb begin
    w_pc_write   = 1'b1;
    w_ifid_write = 1'b1;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    w_start      = 1'b0;
    w_stall_inc  = 1'b0;
    if (bus.EX_branch_taken) begin
      w_ifid_flush = 1'b1;
      w_idex_flush = 1'b1;
    end else if (w_load_use || w_struct) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_idex_flush = 1'b1;
      w_stall_inc  = 1'b1;
    end
    // In IDLE struct is impossible, so only the branch and load-use block issue.
    if (bus.ID_is_muldiv && !w_busy && !bus.EX_branch_taken && !w_load_use) begin
      w_start = 1'b1;
    end
  end

  // Stall-cycle performance counter, saturating at all ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= 32'd0;
    end else if (w_stall_inc && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign bus.PC_write     = w_pc_write;
  assign bus.IFID_write   = w_ifid_write;
  assign bus.IFID_flush   = w_ifid_flush;
  assign bus.IDEX_flush   = w_idex_flush;
  assign bus.muldiv_start = w_start;
  assign bus.muldiv_busy  = w_busy;
  assign bus.muldiv_done  = r_done;
  assign bus.stall_cycles = r_stall_cycles;

endmodule
